// File: rtl/seq_serializer_if.sv
// Load handshake and serial output bundle for seq_serializer.
//   master: producer/observer side (drives load_data, load_valid, bit_en)
//   slave : serializer side (drives load_ready, dout, dout_valid,
//           frame_start, word_done, bit_idx)
interface seq_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IW = $clog2(WIDTH);

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             bit_en;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             word_done;
    logic [IW-1:0]    bit_idx;

    modport master (
        output load_data, load_valid, bit_en,
        input  load_ready, dout, dout_valid, frame_start, word_done, bit_idx
    );

    modport slave (
        input  load_data, load_valid, bit_en,
        output load_ready, dout, dout_valid, frame_start, word_done, bit_idx
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the bit-serial sequence detector.
// Accepts WIDTH-bit words over valid/ready, holds one extra word in a pending
// buffer and emits one bit per bit_en strobe on a registered dout.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - seq_serializer_if.slave: load_data/load_valid/load_ready,
//           bit_en, dout, dout_valid, frame_start, word_done (comb), bit_idx
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    seq_serializer_if.slave   bus
);
    localparam int unsigned   IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic             pend_v, pend_v_n;
    logic [IW-1:0]    idx, idx_n;
    logic             dout_q, dout_n;
    logic             dout_valid_q, dout_valid_n;
    logic             frame_start_q, frame_start_n;

    logic             accept;
    logic             last_retire;
    logic [IW-1:0]    pos_n;

    // Handshake and end-of-word flags seen by the next-state logic.
    assign accept      = bus.load_valid & ~pend_v;
    assign last_retire = (state == S_SHIFT) & bus.bit_en & (idx == LAST);

    // State register; dout and its qualifiers are computed from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            sh            <= '0;
            pend          <= '0;
            pend_v        <= 1'b0;
            idx           <= '0;
            dout_q        <= IDLE_BIT;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state         <= state_n;
            sh            <= sh_n;
            pend          <= pend_n;
            pend_v        <= pend_v_n;
            idx           <= idx_n;
            dout_q        <= dout_n;
            dout_valid_q  <= dout_valid_n;
            frame_start_q <= frame_start_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n  = state;
        sh_n     = sh;
        pend_n   = pend;
        pend_v_n = pend_v;
        idx_n    = idx;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    sh_n    = bus.load_data;
                    idx_n   = '0;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A word arriving on the last-bit edge bypasses pend.
                if (accept && !last_retire) begin
                    pend_n   = bus.load_data;
                    pend_v_n = 1'b1;
                end
                if (bus.bit_en) begin
                    if (idx != LAST) begin
                        idx_n = idx + IW'(1);
                    end else if (pend_v) begin
                        sh_n     = pend;
                        pend_v_n = 1'b0;
                        idx_n    = '0;
                    end else if (accept) begin
                        sh_n  = bus.load_data;
                        idx_n = '0;
                    end else begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n  = S_IDLE;
                pend_v_n = 1'b0;
                idx_n    = '0;
            end
        endcase
    end

    // Registered output values derived from the next state.
    always_comb begin
        pos_n         = MSB_FIRST ? (LAST - idx_n) : idx_n;
        dout_n        = IDLE_BIT;
        dout_valid_n  = 1'b0;
        frame_start_n = 1'b0;
        if (state_n == S_SHIFT) begin
            dout_n        = sh_n[pos_n];
            dout_valid_n  = 1'b1;
            frame_start_n = (idx_n == '0);
        end
    end

    assign bus.load_ready  = ~pend_v;
    assign bus.word_done   = last_retire;
    assign bus.bit_idx     = idx;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the bit-serial sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake, buffers one extra word, and emits one bit at a time on `dout` under an optional pacing strobe. Its output drives the detector's serial `din` input directly. It presents a steady idle level between words so the detector never sees undefined data.

## Interface
- `WIDTH`, 8: word width in bits, ≥2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is emitted first; 0 = bit 0 is emitted first.
- `IDLE_BIT`, 0: value driven on `dout` when no word is being shifted.

- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `load_data`  in  WIDTH: word to serialize.
- `load_valid`  in  1: `load_data` is valid.
- `load_ready`  out  1: block can accept a word this cycle.
- `bit_en`  in  1: shift strobe; the current bit retires at a rising edge only when `bit_en`=1. Tied to 1 when driving the detector.
- `dout`  out  1: current serial bit, registered. This is the detector's `din`.
- `dout_valid`  out  1: `dout` carries word data.
- `frame_start`  out  1: high while bit 0 of a word is on `dout`.
- `word_done`  out  1: combinational; high in the cycle whose edge retires a word's last bit.
- `bit_idx`  out  $clog2(WIDTH): index within the word of the bit currently on `dout`.

## Operation
- Storage:
  - shift register `sh` (WIDTH bits);
  - pending buffer `pend` plus flag `pend_v`;
  - state register with two states, IDLE and SHIFT;
  - counter `bit_idx`.
- Accept = `load_valid` & `load_ready` at a rising edge. `load_ready` = !`pend_v`, a purely combinational value.
- Invariant: in IDLE, `pend_v`=0.
- IDLE:
  - `dout`=IDLE_BIT, `dout_valid`=0.
  - On accept: `sh` <= `load_data`, `bit_idx` <= 0, go to SHIFT.
- SHIFT:
  - `dout_valid`=1; `dout` is the current bit of `sh` in the selected order.
  - An accept in SHIFT writes `pend` and sets `pend_v`, except in the bypass case below.
  - `bit_en`=1 and `bit_idx`<WIDTH-1: advance to the next bit, `bit_idx`+1.
  - `bit_en`=1 and `bit_idx`=WIDTH-1 (`word_done`=1) takes the first matching case:
    - `pend_v`=1: `sh` <= `pend`, `pend_v` <= 0, `bit_idx` <= 0, stay in SHIFT. There is no gap cycle. No accept is possible this cycle because `load_ready`=0.
    - `pend_v`=0 and an accept happens this cycle (bypass): `sh` <= `load_data`, `bit_idx` <= 0, stay in SHIFT. `pend` stays empty.
    - otherwise: go to IDLE. `dout` returns to IDLE_BIT on the same edge.
  - `bit_en`=0: all of `sh`, `bit_idx` and `dout` hold.
- `frame_start` = (state==SHIFT) & (`bit_idx`==0).
- Reset (async, at any time, including mid-word):
  - state=IDLE, `pend_v`=0, `bit_idx`=0, `dout`=IDLE_BIT, `dout_valid`=0, `frame_start`=0, `word_done`=0, `load_ready`=1.
  - In-flight and pending words are discarded.
  - Accepts are ignored while `reset` is high.

## Timing
- Load latency: accept at edge k puts bit 0 on `dout` with `dout_valid`=1 in the cycle after edge k.
- With `bit_en`=1, each word occupies exactly WIDTH cycles.
- A word loaded while the previous one is shifting follows it with zero idle cycles.
- Sustained throughput with `bit_en`=1 is one word per WIDTH cycles. The buffer holds at most two words: `sh` and `pend`.
- `load_ready` falls in the cycle after a pend write. It rises in the cycle after the pend-to-shifter transfer.
- `dout`, `dout_valid` and `bit_idx` are registered and change only at a rising edge or on reset assertion.
- Reset assertion takes effect with no clock edge. The first accept after reset deasserts can occur at the next edge.

## Test plan
- Single word, MSB_FIRST=1, `bit_en`=1: reset, then load 8'hB6.
  - `dout` = 1,0,1,1,0,1,1,0 over cycles 1–8 after the accept.
  - `frame_start` high only in cycle 1; `word_done` high in cycle 8.
  - Cycle 9: `dout`=0, `dout_valid`=0. The downstream detector flags its sequence.
- Back-to-back: load 8'hB6, then load 8'h5A two cycles later.
  - 16 consecutive valid bits, no gap.
  - `load_ready` is 0 from the cycle after the second accept until the cycle after bit 7 of 8'hB6 retires.
- Backpressure: try a third load while `pend_v`=1 with `load_valid` held high.
  - Not accepted while `load_ready`=0.
  - Accepted at the first edge after `load_ready` returns to 1.
  - Its bits follow the second word with no gap.
- Pacing: `bit_en` high one cycle in three, load 8'hB6. Each bit is held 3 cycles, and `word_done` fires on the 8th strobe only.
- Mid-word reset: assert `reset` between edges after 3 bits have been emitted.
  - `dout`=IDLE_BIT, `dout_valid`=0, `bit_idx`=0 immediately.
  - A load after reset deasserts restarts at bit 0 with the new word.
- LSB-first: MSB_FIRST=0, load 8'hB6. `dout` = 0,1,1,0,1,1,0,1.
